// File: rtl/fpu_muldiv_sched_pkg.sv
// rtl/fpu_muldiv_sched_pkg.sv - shared types and helpers for the mul/div scheduler
// Contents: op_e, sched_tag_t, res_entry_t, default latency, result-entry builder.
package fpu_sched_pkg;

  localparam int SCHED_ID_W = 3;   // wide enough for up to 8 requesters
  localparam int DEF_LAT    = 2;
  localparam int OPA_W      = 50;
  localparam int OPB_W      = 24;
  localparam int DATA_W     = 50;
  localparam int PROD_W     = 48;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  typedef struct packed {
    logic [SCHED_ID_W-1:0] id;
    op_e                   op;
    logic                  dbz;
  } sched_tag_t;

  typedef struct packed {
    logic [SCHED_ID_W-1:0] id;
    op_e                   op;
    logic                  dbz;
    logic [DATA_W-1:0]     data;
    logic [DATA_W-1:0]     rem;
  } res_entry_t;

  // Merge a retiring tag with whichever datapath result it belongs to.
  // Divide-by-zero results are zeroed regardless of what the divider returned.
  function automatic res_entry_t make_entry(input sched_tag_t        t,
                                            input logic [PROD_W-1:0] prod,
                                            input logic [DATA_W-1:0] quo,
                                            input logic [DATA_W-1:0] rem);
    res_entry_t e;
    e.id   = t.id;
    e.op   = t.op;
    e.dbz  = t.dbz;
    e.data = '0;
    e.rem  = '0;
    if (t.op == OP_MUL) begin
      e.data = {2'b00, prod};
    end else if (!t.dbz) begin
      e.data = quo;
      e.rem  = rem;
    end
    return e;
  endfunction

endpackage

// File: rtl/fpu_muldiv_sched_if.sv
// rtl/fpu_muldiv_sched_if.sv - requester and result handshake bundle
// master: requester/consumer side (drives req_valid/op/opa/opb, res_ready).
// slave : scheduler side (drives req_ready and the res_* result head).
interface fpu_muldiv_sched_if #(
  parameter int NREQ = 4
) ();

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_op;
  logic [NREQ*50-1:0] req_opa;
  logic [NREQ*24-1:0] req_opb;

  logic               res_valid;
  logic               res_ready;
  logic [IDW-1:0]     res_id;
  logic               res_op;
  logic [49:0]        res_data;
  logic [49:0]        res_rem;
  logic               res_dbz;

  modport master (
    output req_valid, req_op, req_opa, req_opb, res_ready,
    input  req_ready, res_valid, res_id, res_op, res_data, res_rem, res_dbz
  );

  modport slave (
    input  req_valid, req_op, req_opa, req_opb, res_ready,
    output req_ready, res_valid, res_id, res_op, res_data, res_rem, res_dbz
  );

endinterface

// File: rtl/fpu_muldiv_sched_res_fifo.sv
// rtl/fpu_muldiv_sched_res_fifo.sv - in-order result FIFO of res_entry_t with occupancy count
// Ports: clk, reset_n (async, active-low), push/push_data, pop,
//        out_valid/out_data (head, driven from storage flops), count.
module sched_res_fifo
  import fpu_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  res_entry_t                   push_data,
  input  logic                         pop,
  output logic                         out_valid,
  output res_entry_t                   out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  res_entry_t     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_pop;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (int'(p) == DEPTH-1) ? '0 : p + AW'(1);
  endfunction

  assign do_pop    = pop && (count != '0);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fpu_muldiv_sched.sv
// rtl/fpu_muldiv_sched.sv - round-robin scheduler sharing one multiplier and one divider
// Ports: clk, reset_n (async, active-low); bus (fpu_muldiv_sched_if.slave: req_*, res_*);
//        mul_opa/mul_opb -> multiplier, mul_prod <- (LAT cycles later);
//        div_opa/div_opb -> divider, div_quo/div_rem <- (LAT cycles later).
// Optional: define MULDIV_SCHED_PERF_EN to add perf_issue_cnt / perf_stall_cnt outputs.
module fpu_muldiv_sched
  import fpu_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int LAT       = DEF_LAT,
  parameter int RES_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fpu_muldiv_sched_if.slave    bus,
  output logic [23:0]          mul_opa,
  output logic [23:0]          mul_opb,
  input  logic [47:0]          mul_prod,
  output logic [49:0]          div_opa,
  output logic [23:0]          div_opb,
  input  logic [49:0]          div_quo,
  input  logic [49:0]          div_rem
`ifdef MULDIV_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_issue_cnt,
  output logic [31:0]          perf_stall_cnt
`endif
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(RES_DEPTH+1);

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   arb_cand;
  logic             grant_found;
  logic             credit_ok;
  logic             issue;
  int               inflight;

  logic [49:0]      g_opa;
  logic [23:0]      g_opb;
  op_e              g_op;
  sched_tag_t       new_tag;

  logic [LAT-1:0]   tag_vld;
  sched_tag_t       tag_q [LAT];

  res_entry_t       push_entry;
  res_entry_t       fifo_head;
  logic             fifo_valid;
  logic [CW-1:0]    fifo_count;
  logic             id_hi_unused;

  // Credit covers every op that will eventually occupy a FIFO slot, so the
  // FIFO can never overflow even if the consumer stalls indefinitely.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < LAT; i++) inflight += int'(tag_vld[i]);
    credit_ok = (int'(fifo_count) + inflight) < RES_DEPTH;
  end

  // Rotating priority: first valid requester at or after ptr, with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    arb_cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      arb_cand = IDW'((int'(ptr) + i) % NREQ);
      if (!grant_found && bus.req_valid[arb_cand]) begin
        grant_found = 1'b1;
        grant_idx   = arb_cand;
      end
    end
  end

  // Reset gates issue so nothing is granted or driven while reset_n is low.
  assign issue = grant_found && credit_ok && reset_n;

  assign g_opa = bus.req_opa[int'(grant_idx)*50 +: 50];
  assign g_opb = bus.req_opb[int'(grant_idx)*24 +: 24];
  assign g_op  = op_e'(bus.req_op[grant_idx]);

  always_comb begin
    bus.req_ready = '0;
    mul_opa       = '0;
    mul_opb       = '0;
    div_opa       = '0;
    div_opb       = '0;
    new_tag.id    = SCHED_ID_W'(grant_idx);
    new_tag.op    = g_op;
    new_tag.dbz   = (g_op == OP_DIV) && (g_opb == '0);
    if (issue) begin
      bus.req_ready[grant_idx] = 1'b1;
      if (g_op == OP_MUL) begin
        mul_opa = g_opa[23:0];
        mul_opb = g_opb;
      end else begin
        div_opa = g_opa;
        div_opb = g_opb;
      end
    end
  end

  // Tag pipe: the last stage lines up with the datapath result of the same op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr     <= '0;
      tag_vld <= '0;
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      if (issue) ptr <= (int'(grant_idx) == NREQ-1) ? '0 : grant_idx + IDW'(1);
      tag_vld[0] <= issue;
      tag_q[0]   <= new_tag;
      for (int i = 1; i < LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign push_entry = make_entry(tag_q[LAT-1], mul_prod, div_quo, div_rem);

  sched_res_fifo #(
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (tag_vld[LAT-1]),
    .push_data (push_entry),
    .pop       (bus.res_ready),
    .out_valid (fifo_valid),
    .out_data  (fifo_head),
    .count     (fifo_count)
  );

  assign bus.res_valid = fifo_valid;
  assign bus.res_id    = fifo_head.id[IDW-1:0];
  assign bus.res_op    = fifo_head.op;
  assign bus.res_data  = fifo_head.data;
  assign bus.res_rem   = fifo_head.rem;
  assign bus.res_dbz   = fifo_head.dbz;
  assign id_hi_unused  = ^fifo_head.id;

`ifdef MULDIV_SCHED_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue && (perf_issue_cnt != '1))
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if ((|bus.req_valid) && !credit_ok && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_muldiv_sched.sv
// tb/tb_fpu_muldiv_sched.sv - randomized self-checking bench with a transaction-level reference model
module tb_fpu_muldiv_sched;
  import fpu_sched_pkg::*;

  localparam int NREQ      = 4;
  localparam int LAT       = 2;
  localparam int RES_DEPTH = 4;

  typedef struct {
    logic        op;
    logic [49:0] opa;
    logic [23:0] opb;
  } req_t;

  typedef struct {
    int          avail;
    int          id;
    logic        op;
    logic        dbz;
    logic [49:0] data;
    logic [49:0] rem;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fpu_muldiv_sched_if #(.NREQ(NREQ)) bus ();

  logic [23:0] mul_opa, mul_opb;
  logic [47:0] mul_prod;
  logic [49:0] div_opa;
  logic [23:0] div_opb;
  logic [49:0] div_quo, div_rem;
`ifdef MULDIV_SCHED_PERF_EN
  logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

  fpu_muldiv_sched #(
    .NREQ(NREQ), .LAT(LAT), .RES_DEPTH(RES_DEPTH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .mul_opa  (mul_opa),
    .mul_opb  (mul_opb),
    .mul_prod (mul_prod),
    .div_opa  (div_opa),
    .div_opb  (div_opb),
    .div_quo  (div_quo),
    .div_rem  (div_rem)
`ifdef MULDIV_SCHED_PERF_EN
    ,
    .perf_issue_cnt (perf_issue_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Datapath stand-in: LAT-cycle pipelined multiplier and divider.
  // Divide-by-zero returns all ones so the scheduler's zero forcing is visible.
  logic [47:0] mp [LAT];
  logic [49:0] dq [LAT];
  logic [49:0] dr [LAT];
  always @(posedge clk) begin
    mp[0] <= 48'(mul_opa) * 48'(mul_opb);
    dq[0] <= (div_opb == 24'd0) ? '1 : div_opa / 50'(div_opb);
    dr[0] <= (div_opb == 24'd0) ? '1 : div_opa % 50'(div_opb);
    for (int i = 1; i < LAT; i++) begin
      mp[i] <= mp[i-1];
      dq[i] <= dq[i-1];
      dr[i] <= dr[i-1];
    end
  end
  assign mul_prod = mp[LAT-1];
  assign div_quo  = dq[LAT-1];
  assign div_rem  = dr[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  req_t pend [NREQ][$];
  exp_t expq[$];
  int   grants[$];
  int   issue_cycs[$];
  int   ptr_m, outstanding, iss_m, stall_m;
  int   n_tests = 0, n_fail = 0;
  int   dut_iss, dut_pops;
  int   last_issue_cyc, last_pop_cyc;
  logic [49:0] last_data, last_rem;
  logic        last_dbz;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t ref_result(input int id, input req_t r, input int avail);
    exp_t e;
    logic [47:0] p;
    e.avail = avail;
    e.id    = id;
    e.op    = r.op;
    e.dbz   = 1'b0;
    e.data  = '0;
    e.rem   = '0;
    if (r.op == 1'b0) begin
      p      = 48'(r.opa[23:0]) * 48'(r.opb);
      e.data = {2'b00, p};
    end else if (r.opb == 24'd0) begin
      e.dbz = 1'b1;
    end else begin
      e.data = r.opa / 50'(r.opb);
      e.rem  = r.opa % 50'(r.opb);
    end
    return e;
  endfunction

  function automatic int pending_total();
    int n = 0;
    for (int i = 0; i < NREQ; i++) n += pend[i].size();
    return n;
  endfunction

  task automatic drive_inputs();
    logic [NREQ-1:0]    v, o;
    logic [NREQ*50-1:0] a;
    logic [NREQ*24-1:0] b;
    v = '0; o = '0; a = '0; b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pend[i].size() > 0) begin
        v[i]          = 1'b1;
        o[i]          = pend[i][0].op;
        a[i*50 +: 50] = pend[i][0].opa;
        b[i*24 +: 24] = pend[i][0].opb;
      end
    end
    bus.req_valid = v;
    bus.req_op    = o;
    bus.req_opa   = a;
    bus.req_opb   = b;
  endtask

  // One clock: drive, check at negedge against the model, advance the model.
  task automatic step();
    int              g;
    logic [NREQ-1:0] exp_rdy;
    logic            exp_v;
    req_t            r;
    exp_t            e;
    drive_inputs();
    @(negedge clk);
    g = -1;
    if (outstanding < RES_DEPTH) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (ptr_m + k) % NREQ;
        if (g < 0 && pend[j].size() > 0) g = j;
      end
    end else if (pending_total() > 0) begin
      stall_m++;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_val("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    if (bus.req_ready != '0) dut_iss++;
    if (g >= 0) begin
      r = pend[g][0];
      if (r.op == 1'b0) begin
        check_val("mul_opa", 64'(mul_opa), 64'(r.opa[23:0]));
        check_val("mul_opb", 64'(mul_opb), 64'(r.opb));
        check_val("div_idle", 64'(div_opa) | 64'(div_opb), 64'd0);
      end else begin
        check_val("div_opa", 64'(div_opa), 64'(r.opa));
        check_val("div_opb", 64'(div_opb), 64'(r.opb));
        check_val("mul_idle", 64'(mul_opa) | 64'(mul_opb), 64'd0);
      end
    end else begin
      check_val("ports_idle", 64'(|{mul_opa, mul_opb, div_opa, div_opb}), 64'd0);
    end
    exp_v = (expq.size() > 0) && (expq[0].avail <= cyc);
    check_val("res_valid", 64'(bus.res_valid), 64'(exp_v));
    if (exp_v && bus.res_valid) begin
      e = expq[0];
      check_val("res_id",   64'(bus.res_id),   64'(e.id));
      check_val("res_op",   64'(bus.res_op),   64'(e.op));
      check_val("res_dbz",  64'(bus.res_dbz),  64'(e.dbz));
      check_val("res_data", 64'(bus.res_data), 64'(e.data));
      check_val("res_rem",  64'(bus.res_rem),  64'(e.rem));
    end
    if (bus.res_valid && bus.res_ready) begin
      dut_pops++;
      last_pop_cyc = cyc;
      last_data    = bus.res_data;
      last_rem     = bus.res_rem;
      last_dbz     = bus.res_dbz;
    end
    if (g >= 0) begin
      expq.push_back(ref_result(g, pend[g][0], cyc + LAT + 1));
      grants.push_back(g);
      issue_cycs.push_back(cyc);
      last_issue_cyc = cyc;
      pend[g].delete(0);
      ptr_m = (g + 1) % NREQ;
      outstanding++;
      iss_m++;
    end
    if (exp_v && bus.res_ready) begin
      expq.delete(0);
      outstanding--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NREQ; i++) pend[i].delete();
    expq.delete();
    grants.delete();
    issue_cycs.delete();
    ptr_m = 0; outstanding = 0; iss_m = 0; stall_m = 0;
    dut_iss = 0; dut_pops = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_model();
    drive_inputs();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic drain();
    bus.res_ready = 1'b1;
    for (int n = 0; n < 300 && (expq.size() > 0 || pending_total() > 0); n++) step();
    check_val("drain_done", 64'(expq.size() + pending_total()), 64'd0);
  endtask

  function automatic req_t mk(input logic op, input logic [49:0] a, input logic [23:0] b);
    req_t r;
    r.op = op; r.opa = a; r.opb = b;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n       = 1'b0;
    bus.res_ready = 1'b0;
    clear_model();
    pend[1].push_back(mk(1'b0, 50'd9, 24'd9));
    drive_inputs();
    @(negedge clk);
    check_val("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check_val("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check_val("rst_ports", 64'(|{mul_opa, mul_opb, div_opa, div_opb}), 64'd0);
    do_reset();

    // Single MUL from requester 0.
    bus.res_ready = 1'b1;
    pend[0].push_back(mk(1'b0, 50'd3, 24'd5));
    drain();
    check_val("mul_latency", 64'(last_pop_cyc - last_issue_cyc), 64'(LAT + 1));
    check_val("mul_data", 64'(last_data), 64'd15);
    check_val("mul_rem", 64'(last_rem), 64'd0);

    // DIV from requester 2, then divide by zero.
    pend[2].push_back(mk(1'b1, 50'd100, 24'd7));
    drain();
    check_val("div_quo", 64'(last_data), 64'd14);
    check_val("div_rem", 64'(last_rem), 64'd2);
    check_val("div_dbz0", 64'(last_dbz), 64'd0);
    pend[2].push_back(mk(1'b1, 50'd100, 24'd0));
    drain();
    check_val("dbz_flag", 64'(last_dbz), 64'd1);
    check_val("dbz_data", 64'(last_data), 64'd0);

    // All four requesters continuously valid.
    do_reset();
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 2; k++)
        pend[i].push_back(mk(1'(k), 50'($urandom_range(1, 100000)), 24'($urandom_range(1, 5000))));
    drain();
    for (int k = 0; k < 5; k++) check_val($sformatf("rr_order%0d", k), 64'(grants[k]), 64'(k % NREQ));
    check_val("rr_back_to_back", 64'(issue_cycs[7] - issue_cycs[0]), 64'd7);

    // Credit limit with a stalled consumer.
    do_reset();
    bus.res_ready = 1'b0;
    pend[0].push_back(mk(1'b0, 50'd11, 24'd13));
    pend[0].push_back(mk(1'b1, 50'd1000, 24'd33));
    pend[1].push_back(mk(1'b0, 50'd7, 24'd7));
    pend[1].push_back(mk(1'b1, 50'd5, 24'd0));
    pend[2].push_back(mk(1'b0, 50'hFFFFFF, 24'hFFFFFF));
    pend[3].push_back(mk(1'b1, 50'h3_FFFF_FFFF_FFFF, 24'd3));
    for (int n = 0; n < 8; n++) step();
    check_val("credit_issued", 64'(dut_iss), 64'(RES_DEPTH));
    check_val("credit_ready_low", 64'(bus.req_ready), 64'd0);
    drain();
    check_val("credit_all_issued", 64'(dut_iss), 64'd6);
    check_val("credit_all_popped", 64'(dut_pops), 64'd6);

    // Randomized traffic with random consumer backpressure.
    for (int n = 0; n < 400; n++) begin
      int i;
      i = $urandom_range(0, NREQ-1);
      if ($urandom_range(0, 1) == 0 && pend[i].size() < 3)
        pend[i].push_back(mk(1'($urandom), {18'($urandom), 32'($urandom)} >> $urandom_range(0, 40),
                             ($urandom_range(0, 7) == 0) ? 24'd0 : 24'($urandom) >> $urandom_range(0, 20)));
      bus.res_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // Reset with one result in the FIFO and two in flight.
    bus.res_ready = 1'b0;
    pend[0].push_back(mk(1'b0, 50'd2, 24'd2));
    pend[1].push_back(mk(1'b0, 50'd4, 24'd4));
    pend[2].push_back(mk(1'b1, 50'd9, 24'd3));
    for (int n = 0; n < 3; n++) step();
    check_val("pre_rst_valid", 64'(bus.res_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_valid", 64'(bus.res_valid), 64'd0);
    check_val("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    clear_model();
    @(posedge clk);
    #1;
    reset_n       = 1'b1;
    bus.res_ready = 1'b1;
    for (int n = 0; n < 8; n++) step();
    check_val("no_stale_pops", 64'(dut_pops), 64'd0);

`ifdef MULDIV_SCHED_PERF_EN
    // Five issues with three credit-stall cycles.
    do_reset();
    bus.res_ready = 1'b0;
    for (int k = 0; k < 5; k++) pend[0].push_back(mk(1'b0, 50'(k + 1), 24'd3));
    for (int n = 0; n < 6; n++) step();
    bus.res_ready = 1'b1;
    drain();
    check_val("perf_issue", 64'(perf_issue_cnt), 64'd5);
    check_val("perf_stall", 64'(perf_stall_cnt), 64'd3);
    check_val("perf_issue_model", 64'(perf_issue_cnt), 64'(iss_m));
    check_val("perf_stall_model", 64'(perf_stall_cnt), 64'(stall_m));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
